// File: rtl/knn_pkg.sv
// Shared types and constants for the k-nearest-neighbour selector.
// Optional build macro used by the selector: KNN_DIST_OUT_EN.
package knn_pkg;

  localparam int K_NN        = 5;
  localparam int DIST_W_DEF  = 16;
  localparam int LABEL_W_DEF = 2;

  typedef logic [DIST_W_DEF-1:0]  dist_t;
  typedef logic [LABEL_W_DEF-1:0] label_t;

  localparam dist_t DIST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    return (cnt == 3'(K_NN)) ? cnt : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/knn_slot_cmp.sv
// Per-slot comparator: flags that a new sample belongs ahead of this slot.
module knn_slot_cmp #(
  parameter int DIST_W = 16
) (
  input  logic [DIST_W-1:0] slot_dist,
  input  logic [DIST_W-1:0] new_dist,
  output logic              nearer
);

  // Strict compare keeps earlier samples ahead of equal later ones.
  assign nearer = (slot_dist > new_dist);

endmodule

// File: rtl/knn_select.sv
// Streams (distance, label) pairs and keeps a sorted top-5 nearest list.
// Define KNN_DIST_OUT_EN to expose the stored slot distances as dist_nn1..dist_nn5.
module knn_select
  import knn_pkg::*;
#(
  parameter int DIST_W  = 16,
  parameter int LABEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIST_W-1:0]  in_dist,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_last,
  output logic               res_valid,
  input  logic               res_ack,
  output logic [LABEL_W-1:0] label_nn1,
  output logic [LABEL_W-1:0] label_nn2,
  output logic [LABEL_W-1:0] label_nn3,
  output logic [LABEL_W-1:0] label_nn4,
  output logic [LABEL_W-1:0] label_nn5,
`ifdef KNN_DIST_OUT_EN
  output logic [DIST_W-1:0]  dist_nn1,
  output logic [DIST_W-1:0]  dist_nn2,
  output logic [DIST_W-1:0]  dist_nn3,
  output logic [DIST_W-1:0]  dist_nn4,
  output logic [DIST_W-1:0]  dist_nn5,
`endif
  output logic [2:0]         fill_cnt
);

  state_e               state_q, state_d;
  logic [DIST_W-1:0]    dist_q  [K_NN];
  logic [DIST_W-1:0]    dist_d  [K_NN];
  logic [LABEL_W-1:0]   label_q [K_NN];
  logic [LABEL_W-1:0]   label_d [K_NN];
  logic [2:0]           fill_q, fill_d;

  logic [K_NN-1:0]      nearer_s;
  logic [K_NN-1:0]      prev_nearer_s;
  logic [DIST_W-1:0]    src_dist_s  [K_NN];
  logic [LABEL_W-1:0]   src_label_s [K_NN];

  // Slot i takes the new sample when it is the first nearer slot, else its upper neighbour.
  for (genvar g = 0; g < K_NN; g++) begin : g_slot
    knn_slot_cmp #(.DIST_W(DIST_W)) u_cmp (
      .slot_dist (dist_q[g]),
      .new_dist  (in_dist),
      .nearer    (nearer_s[g])
    );
    if (g == 0) begin : g_head
      assign prev_nearer_s[g] = 1'b0;
      assign src_dist_s[g]    = in_dist;
      assign src_label_s[g]   = in_label;
    end else begin : g_tail
      assign prev_nearer_s[g] = nearer_s[g-1];
      assign src_dist_s[g]    = prev_nearer_s[g] ? dist_q[g-1]  : in_dist;
      assign src_label_s[g]   = prev_nearer_s[g] ? label_q[g-1] : in_label;
    end
  end

  // Next-state, insertion and query-clear logic.
  always_comb begin
    state_d = state_q;
    dist_d  = dist_q;
    label_d = label_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          fill_d  = 3'd0;
          for (int i = 0; i < K_NN; i++) begin
            dist_d[i]  = {DIST_W{1'b1}};
            label_d[i] = {LABEL_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          fill_d = sat_inc(fill_q);
          for (int i = 0; i < K_NN; i++) begin
            if (nearer_s[i]) begin
              dist_d[i]  = src_dist_s[i];
              label_d[i] = src_label_s[i];
            end else begin
              dist_d[i]  = dist_q[i];
              label_d[i] = label_q[i];
            end
          end
          state_d = in_last ? DONE : COLLECT;
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        if (res_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= 3'd0;
      for (int i = 0; i < K_NN; i++) begin
        dist_q[i]  <= {DIST_W{1'b1}};
        label_q[i] <= {LABEL_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      dist_q  <= dist_d;
      label_q <= label_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign res_valid = (state_q == DONE);
  assign fill_cnt  = fill_q;
  assign label_nn1 = label_q[0];
  assign label_nn2 = label_q[1];
  assign label_nn3 = label_q[2];
  assign label_nn4 = label_q[3];
  assign label_nn5 = label_q[4];
`ifdef KNN_DIST_OUT_EN
  assign dist_nn1  = dist_q[0];
  assign dist_nn2  = dist_q[1];
  assign dist_nn3  = dist_q[2];
  assign dist_nn4  = dist_q[3];
  assign dist_nn5  = dist_q[4];
`endif

endmodule
